// File: rtl/pkt_fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : pkt_fifo_wr_arbiter_pkg
// Brief  : Shared definitions for the packet FIFO write-side arbiter:
//          FSM state encoding, default maximum frame length and the layout
//          of the 9-bit FIFO word ({data[7:0], eod}, EOD in bit 0).
// Rev    : 1.0  initial release
// ============================================================================
package pkt_fifo_wr_arbiter_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_PASS  = PASS,
    S_FLUSH = FLUSH,
    S_GAP   = GAP
  } arb_state_t;

  localparam int MAX_FRAME_DEF = 1518;

  // FIFO word: data in bits [8:1], end-of-data marker in bit EOD_BIT.
  localparam int FIFO_W  = 9;
  localparam int EOD_BIT = 0;

  function automatic logic [FIFO_W-1:0] pack_word(input logic [7:0] data,
                                                  input logic       eod);
    return {data, eod};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : pkt_fifo_wr_arbiter_rr_pick
// Brief  : Combinational round-robin priority encoder. Returns a one-hot
//          pick of the first asserted req at or after last_winner+1,
//          wrapping modulo NREQ. pick is all-zero when req is all-zero.
// Ports  : req         in  NREQ   request vector
//          last_winner in  IDX_W  index of the previous winner
//          pick        out NREQ   one-hot selection
// Rev    : 1.0  initial release
// ============================================================================
module pkt_fifo_wr_arbiter_rr_pick
  import pkt_fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [NREQ-1:0]  pick
);

  // One extra bit so last_winner + NREQ cannot overflow before the wrap.
  localparam logic [IDX_W:0] C_NREQ = (IDX_W+1)'(NREQ);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_winner} + (IDX_W+1)'(k);
      if (cand >= C_NREQ) begin
        cand = cand - C_NREQ;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        pick[cand[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pkt_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pkt_fifo_wr_arbiter
// Brief  : Frame-atomic round-robin arbiter sharing one packet-FIFO write
//          port among NREQ byte producers. One whole frame per grant, new
//          grants held off while the FIFO is almost-full, overlong frames
//          truncated at MAX_FRAME bytes with a forced EOD.
// Ports  : clkw, rst_n (async, active-low)
//          req/gnt                       per-requester request / grant
//          src_di/src_we/src_eod/src_rdy per-requester byte stream
//          fifo_di/fifo_we/fifo_eod      FIFO write port
//          fifo_full/fifo_afull          FIFO status
//          trunc_err                     pulse on the truncated byte
// Config : PKT_ARB_STATS_EN adds frame_cnt (16 bits per requester) and
//          trunc_cnt (16 bits), both saturating.
// Rev    : 1.0  initial release
// ============================================================================
module pkt_fifo_wr_arbiter
  import pkt_fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_FRAME = MAX_FRAME_DEF,
  parameter int CNT_W     = 11
) (
  input  logic              clkw,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [8*NREQ-1:0] src_di,
  input  logic [NREQ-1:0]   src_we,
  input  logic [NREQ-1:0]   src_eod,
  output logic [NREQ-1:0]   src_rdy,
  output logic [7:0]        fifo_di,
  output logic              fifo_we,
  output logic              fifo_eod,
  input  logic              fifo_full,
  input  logic              fifo_afull,
  output logic              trunc_err
`ifdef PKT_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0] frame_cnt,
  output logic [15:0]        trunc_cnt
`endif
);

  localparam int               IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_FRAME - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] last_winner;
  logic [CNT_W-1:0] count;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;
  logic             accept;
  logic             done;
  logic             trunc;

  pkt_fifo_wr_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner),
    .pick        (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    src_rdy   = '0;
    fifo_we   = 1'b0;
    fifo_di   = '0;
    fifo_eod  = 1'b0;
    trunc_err = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    trunc     = 1'b0;
    case (state)
      S_IDLE: begin
        if ((|req) && !fifo_afull) begin
          state_nxt = S_PASS;
        end
      end
      S_PASS: begin
        fifo_di      = src_di[{sel, 3'b000} +: 8];
        fifo_eod     = src_eod[sel];
        src_rdy[sel] = !fifo_full;
        accept       = src_we[sel] & !fifo_full;
        fifo_we      = accept;
        if (accept) begin
          if (src_eod[sel]) begin
            done      = 1'b1;
            state_nxt = S_GAP;
          end else if (count == C_LAST) begin
            // Terminate the frame in the FIFO on its last allowed byte.
            trunc     = 1'b1;
            fifo_eod  = 1'b1;
            trunc_err = 1'b1;
            state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        src_rdy[sel] = 1'b1;
        if (src_we[sel] && src_eod[sel]) begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkw or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sel         <= '0;
      // Point at the highest index so requester 0 wins first after reset.
      last_winner <= IDX_W'(NREQ - 1);
      gnt         <= '0;
      count       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (state_nxt == S_PASS) begin
            gnt   <= pick;
            sel   <= pick_idx;
            count <= '0;
          end
        end
        S_PASS: begin
          if (done) begin
            gnt         <= '0;
            last_winner <= sel;
            count       <= '0;
          end else if (trunc) begin
            count <= '0;
          end else if (accept) begin
            count <= count + CNT_W'(1);
          end
        end
        S_FLUSH: begin
          // A truncated frame also counts as this requester's turn.
          if (state_nxt == S_GAP) begin
            gnt         <= '0;
            last_winner <= sel;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PKT_ARB_STATS_EN
  // A truncated frame still ends with EOD in the FIFO, so it counts as a
  // completed frame as well as a truncation.
  logic        frame_end;
  logic [15:0] fcnt [NREQ];

  assign frame_end = (state == S_PASS) && (done || trunc);

  for (genvar i = 0; i < NREQ; i++) begin : g_frame_cnt
    always_ff @(posedge clkw or negedge rst_n) begin
      if (!rst_n) begin
        fcnt[i] <= '0;
      end else if (frame_end && gnt[i] && (fcnt[i] != 16'hFFFF)) begin
        fcnt[i] <= fcnt[i] + 16'd1;
      end
    end
    assign frame_cnt[16*i +: 16] = fcnt[i];
  end

  always_ff @(posedge clkw or negedge rst_n) begin
    if (!rst_n) begin
      trunc_cnt <= '0;
    end else if (trunc && (trunc_cnt != 16'hFFFF)) begin
      trunc_cnt <= trunc_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_pkt_fifo_wr_arbiter
// Brief  : Self-checking bench for pkt_fifo_wr_arbiter (NREQ=2,
//          MAX_FRAME=1518). Source models feed per-requester byte queues,
//          expected FIFO words are queued at load time and compared as the
//          FIFO is written. Frame scenarios come from a vector table;
//          almost-full hold-off, reset mid-frame and round-robin ordering
//          are hand-written sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pkt_fifo_wr_arbiter;
  import pkt_fifo_wr_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int MAXF = 1518;

  logic              clkw = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [8*NREQ-1:0] src_di;
  logic [NREQ-1:0]   src_we;
  logic [NREQ-1:0]   src_eod;
  logic [NREQ-1:0]   src_rdy;
  logic [7:0]        fifo_di;
  logic              fifo_we;
  logic              fifo_eod;
  logic              fifo_full;
  logic              fifo_afull;
  logic              trunc_err;
`ifdef PKT_ARB_STATS_EN
  logic [16*NREQ-1:0] frame_cnt;
  logic [15:0]        trunc_cnt;
`endif

  pkt_fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .MAX_FRAME (MAXF),
    .CNT_W     (11)
  ) dut (
    .clkw       (clkw),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .src_di     (src_di),
    .src_we     (src_we),
    .src_eod    (src_eod),
    .src_rdy    (src_rdy),
    .fifo_di    (fifo_di),
    .fifo_we    (fifo_we),
    .fifo_eod   (fifo_eod),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .trunc_err  (trunc_err)
`ifdef PKT_ARB_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .trunc_cnt  (trunc_cnt)
`endif
  );

  always #5 clkw = ~clkw;

  typedef struct {
    int rq;
    int len;
    int bub;
    int stall_at;
    int stall_len;
    int exp_w;
    int exp_t;
  } vec_t;

  typedef struct {
    int         rq;
    logic [8:0] w;
  } exp_t;

  vec_t       vecs [5];
  exp_t       expq [$];
  logic [8:0] srcq0 [$];
  logic [8:0] srcq1 [$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_writes, n_eod, n_trunc, sb_err, proto_err;
  int first_gnt, req_cyc, n_rise, zrun, min_gap;
  int bubble = 0;
  int stall_at = 0;
  int stall_left = 0;
  bit afull = 1'b0;
  bit seen_frame;
  logic [NREQ-1:0] s_gnt, prev_gnt, first_gnt_val;
  logic [8:0] sb_got, sb_want;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic clr_stats();
    n_writes   = 0;
    n_eod      = 0;
    n_trunc    = 0;
    sb_err     = 0;
    proto_err  = 0;
    first_gnt  = -1;
    n_rise     = 0;
    zrun       = 0;
    min_gap    = 1000;
    seen_frame = 1'b0;
    first_gnt_val = '0;
  endtask

  task automatic load_frame(input int rq, input int len, input int tag);
    logic [7:0] d;
    exp_t       e;
    for (int b = 1; b <= len; b++) begin
      d = 8'((tag * 16) + (b * 3) + (rq * 101));
      if (rq == 0) srcq0.push_back(pack_word(d, b == len));
      else         srcq1.push_back(pack_word(d, b == len));
      if (b <= MAXF) begin
        e.rq = rq;
        e.w  = pack_word(d, (b == len) || (b == MAXF));
        expq.push_back(e);
      end
    end
  endtask

  // Inputs change on the falling edge.
  task automatic drive();
    bit bub_now;
    bub_now = (bubble != 0) && ((cyc % 3) == 2);
    req     = {srcq1.size() != 0, srcq0.size() != 0};
    src_we  = '0;
    src_di  = '0;
    src_eod = '0;
    if (srcq0.size() != 0) begin
      src_di[7:0] = srcq0[0][8:1];
      src_eod[0]  = srcq0[0][EOD_BIT];
      src_we[0]   = gnt[0] && !bub_now;
    end
    if (srcq1.size() != 0) begin
      src_di[15:8] = srcq1[0][8:1];
      src_eod[1]   = srcq1[0][EOD_BIT];
      src_we[1]    = gnt[1] && !bub_now;
    end
    fifo_afull = afull;
    if (stall_left > 0 && n_writes == stall_at) begin
      fifo_full  = 1'b1;
      stall_left = stall_left - 1;
    end else begin
      fifo_full = 1'b0;
    end
  endtask

  // Outputs sampled one time unit before the rising edge.
  task automatic sample();
    exp_t e;
    s_gnt = gnt;
    if (gnt != 0 && first_gnt < 0) begin
      first_gnt     = cyc;
      first_gnt_val = gnt;
    end
    if (gnt == 0) zrun++;
    else begin
      if (prev_gnt == 0) begin
        if (seen_frame && zrun < min_gap) min_gap = zrun;
        n_rise++;
      end
      seen_frame = 1'b1;
      zrun       = 0;
    end
    if (gnt != 0 && prev_gnt != 0 && gnt != prev_gnt) proto_err++;
    if (!$onehot0(gnt)) proto_err++;
    if ((src_rdy & ~gnt) != 0) proto_err++;
    if (fifo_full && (fifo_we || src_rdy != 0)) proto_err++;
    if (trunc_err) n_trunc++;
    if (fifo_we) begin
      n_writes++;
      if (fifo_eod) n_eod++;
      if (expq.size() == 0) begin
        if (sb_err == 0) begin
          sb_got  = {fifo_di, fifo_eod};
          sb_want = '0;
        end
        sb_err++;
      end else begin
        e = expq.pop_front();
        if (gnt != (2'b01 << e.rq) || {fifo_di, fifo_eod} != e.w) begin
          if (sb_err == 0) begin
            sb_got  = {fifo_di, fifo_eod};
            sb_want = e.w;
          end
          sb_err++;
        end
      end
    end
    if (src_we[0] && src_rdy[0]) void'(srcq0.pop_front());
    if (src_we[1] && src_rdy[1]) void'(srcq1.pop_front());
    prev_gnt = gnt;
    cyc++;
  endtask

  task automatic step();
    drive();
    #4;
    sample();
    @(negedge clkw);
  endtask

  task automatic run_frames(input int limit, output bit ok);
    int g;
    g = 0;
    while ((srcq0.size() != 0 || srcq1.size() != 0) && g < limit) begin
      step();
      g++;
    end
    ok = (srcq0.size() == 0) && (srcq1.size() == 0);
  endtask

  task automatic chk_sb(input string name);
    chk($sformatf("%s scoreboard (first got %h want %h)", name, sb_got, sb_want),
        64'(sb_err + expq.size()), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int g;

    vecs[0] = '{rq: 0, len:   64, bub: 0, stall_at:  0, stall_len: 0, exp_w:   64, exp_t: 0};
    vecs[1] = '{rq: 1, len:    1, bub: 0, stall_at:  0, stall_len: 0, exp_w:    1, exp_t: 0};
    vecs[2] = '{rq: 1, len:   40, bub: 1, stall_at: 10, stall_len: 5, exp_w:   40, exp_t: 0};
    vecs[3] = '{rq: 0, len: 1518, bub: 0, stall_at:  0, stall_len: 0, exp_w: 1518, exp_t: 0};
    vecs[4] = '{rq: 0, len: 1600, bub: 0, stall_at:  0, stall_len: 0, exp_w: 1518, exp_t: 1};

    rst_n      = 1'b0;
    req        = '0;
    src_di     = '0;
    src_we     = '0;
    src_eod    = '0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    prev_gnt   = '0;
    sb_got     = '0;
    sb_want    = '0;
    clr_stats();

    #4;
    chk("reset gnt",       64'(gnt),       0);
    chk("reset src_rdy",   64'(src_rdy),   0);
    chk("reset fifo_we",   64'(fifo_we),   0);
    chk("reset fifo_eod",  64'(fifo_eod),  0);
    chk("reset fifo_di",   64'(fifo_di),   0);
    chk("reset trunc_err", 64'(trunc_err), 0);

    @(negedge clkw);
    rst_n = 1'b1;
    step();
    step();

    // ---------------- table-driven single-frame scenarios ----------------
    for (int i = 0; i < 5; i++) begin
      clr_stats();
      bubble     = vecs[i].bub;
      stall_at   = vecs[i].stall_at;
      stall_left = vecs[i].stall_len;
      load_frame(vecs[i].rq, vecs[i].len, i);
      req_cyc = cyc;
      run_frames(vecs[i].len * 3 + 50, ok);
      chk($sformatf("v%0d frame consumed", i), 64'(ok), 1);
      chk($sformatf("v%0d grant latency", i), 64'(first_gnt - req_cyc), 1);
      chk($sformatf("v%0d granted requester", i), 64'(first_gnt_val), 64'(2'b01 << vecs[i].rq));
      chk($sformatf("v%0d fifo writes", i), 64'(n_writes), 64'(vecs[i].exp_w));
      chk($sformatf("v%0d eod count", i), 64'(n_eod), 1);
      chk($sformatf("v%0d trunc pulses", i), 64'(n_trunc), 64'(vecs[i].exp_t));
      chk($sformatf("v%0d protocol errors", i), 64'(proto_err), 0);
      chk_sb($sformatf("v%0d", i));
      step();
      chk($sformatf("v%0d gap gnt", i), 64'(s_gnt), 0);
      step();
      bubble = 0;
    end

`ifdef PKT_ARB_STATS_EN
    chk("trunc_cnt", 64'(trunc_cnt), 1);
    chk("frame_cnt req1", 64'(frame_cnt[31:16]), 2);
`endif

    // ---------------- almost-full hold-off ----------------
    clr_stats();
    afull = 1'b1;
    load_frame(0, 8, 9);
    for (int i = 0; i < 20; i++) step();
    chk("afull no grant", 64'(first_gnt < 0), 1);
    afull   = 1'b0;
    req_cyc = cyc;
    g = 0;
    while (srcq0.size() != 0 && g < 100) begin
      step();
      g++;
      if (n_writes >= 2) afull = 1'b1;
    end
    afull = 1'b0;
    chk("afull grant latency", 64'(first_gnt - req_cyc), 1);
    chk("afull mid-frame writes", 64'(n_writes), 8);
    chk_sb("afull");
    step();
    step();

    // ---------------- reset on byte 30 ----------------
    clr_stats();
    load_frame(0, 100, 7);
    g = 0;
    while (n_writes < 29 && g < 300) begin
      step();
      g++;
    end
    drive();
    #2;
    chk("byte30 presented", 64'(fifo_we), 1);
    rst_n = 1'b0;
    #1;
    chk("async reset gnt", 64'(gnt), 0);
    chk("async reset fifo_we", 64'(fifo_we), 0);
    chk("async reset src_rdy", 64'(src_rdy), 0);
    srcq0.delete();
    expq.delete();
    @(negedge clkw);
    drive();
    @(negedge clkw);
    rst_n    = 1'b1;
    prev_gnt = '0;

    // ---------------- round-robin, both requesting ----------------
    clr_stats();
    load_frame(0, 5, 1);
    load_frame(1, 4, 2);
    load_frame(0, 7, 3);
    load_frame(1, 6, 4);
    load_frame(0, 3, 5);
    load_frame(1, 2, 6);
    req_cyc = cyc;
    run_frames(500, ok);
    chk("rr frames consumed", 64'(ok), 1);
    chk("rr grant latency", 64'(first_gnt - req_cyc), 1);
    chk("rr first winner after reset", 64'(first_gnt_val), 1);
    chk("rr grant count", 64'(n_rise), 6);
    chk("rr min gap", 64'(min_gap), 2);
    chk("rr writes", 64'(n_writes), 27);
    chk("rr eod count", 64'(n_eod), 6);
    chk("rr protocol errors", 64'(proto_err), 0);
    chk_sb("rr");
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
